// File: rtl/pwm_preconditioner.sv
// pwm_preconditioner: converts filtered duty/phase pairs into PWM rise/fall compare points.
// One transducer per clock flows through a 3-stage pipeline into a result buffer; the whole
// array is copied to the outputs in a single cycle so downstream generators never see a mix.
module pwm_preconditioner #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 249
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_cycle [DEPTH],
  input  logic [WIDTH-1:0] i_duty  [DEPTH],
  input  logic [WIDTH-1:0] i_phase [DEPTH],
  output logic [WIDTH-1:0] o_rise  [DEPTH],
  output logic [WIDTH-1:0] o_fall  [DEPTH],
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StPublish} state_e;

  state_e r_state, w_state_d;
  logic   r_done;

  logic [WIDTH-1:0] r_cyc_sh [DEPTH];
  logic [WIDTH-1:0] r_dut_sh [DEPTH];
  logic [WIDTH-1:0] r_ph_sh  [DEPTH];
  logic [WIDTH-1:0] r_buf_rise [DEPTH];
  logic [WIDTH-1:0] r_buf_fall [DEPTH];
  logic [WIDTH-1:0] w_buf_rise [DEPTH];
  logic [WIDTH-1:0] w_buf_fall [DEPTH];

  logic [CW-1:0] r_idx;
  logic [IW-1:0] w_rd_idx;
  logic          w_feed, w_load, w_publish;

  // Stage 1 registers: clamped duty, folded phase
  logic             r_s1_vld;
  logic [IW-1:0]    r_s1_idx;
  logic [WIDTH-1:0] r_s1_c, r_s1_dc, r_s1_pf;
  logic [WIDTH-1:0] w_c1, w_d1, w_p1, w_dc1, w_pf1;

  // Stage 2 registers: unwrapped rise/fall points
  logic                r_s2_vld;
  logic [IW-1:0]       r_s2_idx;
  logic [WIDTH-1:0]    r_s2_c, r_s2_dc;
  logic signed [SW-1:0] r_s2_r, r_s2_f;
  logic [WIDTH-1:0]    w_lo2, w_hi2;
  logic signed [SW-1:0] w_r2, w_f2;

  // Stage 3 (combinational into buffer): wrapped and special-cased results
  logic signed [SW-1:0] w_c3, w_r3_full, w_f3_full;
  logic [WIDTH-1:0]    w_rise3, w_fall3;

  assign w_load    = (r_state == StIdle) && i_start && !r_done;
  assign w_feed    = (r_state == StRun) && (r_idx < CW'(DEPTH));
  assign w_publish = (r_state == StPublish);
  assign w_rd_idx  = r_idx[IW-1:0];
  assign o_busy    = (r_state != StIdle) || r_done;
  assign o_done    = r_done;

  // FSM next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_load) w_state_d = StRun;
      // Leave one cycle early so the last result is written while the copy happens
      StRun:     if (r_s1_vld && (r_s1_idx == IW'(DEPTH - 1))) w_state_d = StPublish;
      StPublish: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // FSM state and DONE pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_done  <= w_publish;
    end
  end

  // Shadow copies of the inputs, captured only on an accepted START
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cyc_sh[i] <= '0;
        r_dut_sh[i] <= '0;
        r_ph_sh[i]  <= '0;
      end
    end else if (w_load) begin
      r_cyc_sh <= i_cycle;
      r_dut_sh <= i_duty;
      r_ph_sh  <= i_phase;
    end
  end

  // Feed index counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else if (w_load) begin
      r_idx <= '0;
    end else if (w_feed) begin
      r_idx <= r_idx + CW'(1);
    end
  end

  // Stage 1 arithmetic
  always_comb begin
    w_c1  = r_cyc_sh[w_rd_idx];
    w_d1  = r_dut_sh[w_rd_idx];
    w_p1  = r_ph_sh[w_rd_idx];
    w_dc1 = (w_d1 < w_c1) ? w_d1 : w_c1;
    w_pf1 = (w_p1 >= w_c1) ? (w_p1 - w_c1) : w_p1;
  end

  // Stage 2 arithmetic: centre the pulse on the folded phase
  always_comb begin
    w_lo2 = r_s1_dc >> 1;
    w_hi2 = r_s1_dc - w_lo2;
    w_r2  = $signed({1'b0, r_s1_pf}) - $signed({1'b0, w_lo2});
    w_f2  = $signed({1'b0, r_s1_pf}) + $signed({1'b0, w_hi2});
  end

  // Stage 3 arithmetic: wrap into the period, then apply special cases
  always_comb begin
    w_c3      = $signed({1'b0, r_s2_c});
    w_r3_full = (r_s2_r < 0) ? (r_s2_r + w_c3) : r_s2_r;
    w_f3_full = (r_s2_f >= w_c3) ? (r_s2_f - w_c3) : r_s2_f;
    w_rise3   = w_r3_full[WIDTH-1:0];
    w_fall3   = w_f3_full[WIDTH-1:0];
    if (r_s2_c == '0 || r_s2_dc == '0) begin
      w_rise3 = '0;
      w_fall3 = '0;
    end else if (r_s2_dc == r_s2_c) begin
      w_rise3 = '0;
      w_fall3 = r_s2_c;
    end
  end

  // Pipeline stage registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_idx <= '0;
      r_s1_c   <= '0;
      r_s1_dc  <= '0;
      r_s1_pf  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_idx <= '0;
      r_s2_c   <= '0;
      r_s2_dc  <= '0;
      r_s2_r   <= '0;
      r_s2_f   <= '0;
    end else begin
      r_s1_vld <= w_feed;
      r_s1_idx <= w_rd_idx;
      r_s1_c   <= w_c1;
      r_s1_dc  <= w_dc1;
      r_s1_pf  <= w_pf1;
      r_s2_vld <= r_s1_vld;
      r_s2_idx <= r_s1_idx;
      r_s2_c   <= r_s1_c;
      r_s2_dc  <= r_s1_dc;
      r_s2_r   <= w_r2;
      r_s2_f   <= w_f2;
    end
  end

  // Buffer contents including the result being written this cycle
  always_comb begin
    w_buf_rise = r_buf_rise;
    w_buf_fall = r_buf_fall;
    if (r_s2_vld) begin
      w_buf_rise[r_s2_idx] = w_rise3;
      w_buf_fall[r_s2_idx] = w_fall3;
    end
  end

  // Result buffer and atomically published outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_rise[i] <= '0;
        r_buf_fall[i] <= '0;
        o_rise[i]     <= '0;
        o_fall[i]     <= '0;
      end
    end else begin
      r_buf_rise <= w_buf_rise;
      r_buf_fall <= w_buf_fall;
      if (w_publish) begin
        o_rise <= w_buf_rise;
        o_fall <= w_buf_fall;
      end
    end
  end

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Self-checking bench for pwm_preconditioner (WIDTH=13, DEPTH=4) against a per-index model.
module tb_pwm_preconditioner;

  localparam int W = 13;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] cyc   [D];
  logic [W-1:0] duty  [D];
  logic [W-1:0] phase [D];
  logic [W-1:0] rise  [D];
  logic [W-1:0] fall  [D];
  logic         busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_r [D];
  int exp_f [D];
  int pub_r [D];
  int pub_f [D];

  pwm_preconditioner #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_cycle (cyc),
    .i_duty  (duty),
    .i_phase (phase),
    .o_rise  (rise),
    .o_fall  (fall),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: pulse of width min(d,c) centred on phase (folded once), wrapped into [0,c)
  function automatic void model_one(input int c, input int d, input int p,
                                    output int r, output int f);
    int dc, pf, lo, hi, rr, ff;
    dc = (d < c) ? d : c;
    pf = (p >= c) ? p - c : p;
    lo = dc / 2;
    hi = dc - lo;
    rr = pf - lo;
    ff = pf + hi;
    if (c == 0 || dc == 0) begin
      r = 0;
      f = 0;
    end else if (dc == c) begin
      r = 0;
      f = c;
    end else begin
      r = (rr < 0) ? rr + c : rr;
      f = (ff >= c) ? ff - c : ff;
    end
  endfunction

  function automatic void model_sweep();
    for (int i = 0; i < D; i++) begin
      int r, f;
      model_one(int'(cyc[i]), int'(duty[i]), int'(phase[i]), r, f);
      exp_r[i] = r;
      exp_f[i] = f;
    end
  endfunction

  task automatic check_outputs(input string when);
    for (int i = 0; i < D; i++) begin
      check($sformatf("rise[%0d]%s", i, when), 32'(rise[i]), 32'(pub_r[i]));
      check($sformatf("fall[%0d]%s", i, when), 32'(fall[i]), 32'(pub_f[i]));
    end
  endtask

  // One sweep: START in cycle 0, optional extra START and input perturbation in later cycles
  task automatic run_sweep(input int extra_start, input int perturb);
    int dones = 0;
    @(posedge clk); #1;
    model_sweep();
    start = 1'b1;
    for (int k = 1; k <= D + 6; k++) begin
      @(posedge clk); #1;
      start = (k == extra_start);
      if (k == perturb) begin
        for (int i = 0; i < D; i++) begin
          duty[i]  = W'($urandom_range(0, 8191));
          phase[i] = W'($urandom_range(0, 8191));
        end
      end
      check($sformatf("busy@%0d", k), 32'(busy), 32'(k <= D + 3));
      check($sformatf("done@%0d", k), 32'(done), 32'(k == D + 3));
      if (done) dones++;
      if (k == D + 3) begin
        pub_r = exp_r;
        pub_f = exp_f;
      end
      check_outputs($sformatf("@%0d", k));
    end
    start = 1'b0;
    check("done_count", 32'(dones), 32'd1);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < D; i++) begin
      int c;
      c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4096));
      cyc[i] = W'(c);
      case ($urandom_range(0, 4))
        0:       duty[i] = '0;
        1:       duty[i] = W'(c);
        2:       duty[i] = W'($urandom_range(c, 8191));
        default: duty[i] = W'($urandom_range(0, c));
      endcase
      phase[i] = W'($urandom_range(0, 8191));
    end
  endtask

  task automatic set_all_cycle(input int c);
    for (int i = 0; i < D; i++) cyc[i] = W'(c);
  endtask

  initial begin
    set_all_cycle(4096);
    for (int i = 0; i < D; i++) begin
      duty[i]  = W'($urandom_range(0, 4096));
      phase[i] = W'($urandom_range(0, 8191));
      pub_r[i] = 0;
      pub_f[i] = 0;
    end

    // Reset state
    #12;
    check("busy_rst", 32'(busy), 32'd0);
    check("done_rst", 32'(done), 32'd0);
    check_outputs("_rst");
    @(negedge clk) rst_n = 1'b1;

    // Latency with a START at cycle 3 that must be ignored
    run_sweep(3, 0);

    // Basic and odd duty
    duty[0] = 13'd2048; phase[0] = 13'd1024;
    duty[1] = 13'd101;  phase[1] = 13'd200;
    run_sweep(0, 0);
    check("basic_r0", 32'(pub_r[0]), 32'd0);
    check("basic_f1", 32'(pub_f[1]), 32'd251);

    // Wrap-around
    duty[0] = 13'd100; phase[0] = 13'd0;
    duty[1] = 13'd10;  phase[1] = 13'd4100;
    run_sweep(0, 0);
    check("wrap_r0", 32'(pub_r[0]), 32'd4046);
    check("wrap_r1", 32'(pub_r[1]), 32'd4095);

    // Saturation and zero cases
    duty[0] = 13'd5000;
    duty[1] = 13'd4096;
    duty[2] = 13'd0; phase[2] = 13'd777;
    cyc[3]  = 13'd0;
    run_sweep(0, 0);
    check("sat_f0", 32'(pub_f[0]), 32'd4096);
    check("zero_f2", 32'(pub_f[2]), 32'd0);
    set_all_cycle(4096);

    // Inputs changed at cycle 2 must not affect the sweep
    run_sweep(0, 2);

    // START in the DONE cycle must be ignored
    run_sweep(D + 3, 0);

    // Asynchronous reset at cycle 4 aborts the sweep
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < D; i++) begin
      pub_r[i] = 0;
      pub_f[i] = 0;
    end
    check("busy_arst", 32'(busy), 32'd0);
    check("done_arst", 32'(done), 32'd0);
    check_outputs("_arst");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("done_after_rst@%0d", k), 32'(done), 32'd0);
      check($sformatf("busy_after_rst@%0d", k), 32'(busy), 32'd0);
    end
    check_outputs("_post_rst");
    run_sweep(0, 0);

    // Randomized sweeps
    for (int n = 0; n < 25; n++) begin
      rand_inputs();
      run_sweep(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D + 3)) : 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_preconditioner.md
Name: pwm_preconditioner

Overview:
- Sits directly downstream of the silent LPF.
- On each LPF completion it converts every transducer's filtered duty/phase pair into the PWM rise and fall compare points consumed by the PWM generators.
- It processes one transducer per clock through a 3-stage pipeline.
- All RISE/FALL outputs are published atomically when the sweep ends, so the PWM generators never see a half-updated array.

Parameters:
- WIDTH, 13: bit width of cycle/duty/phase/rise/fall values.
- DEPTH, 249: number of transducers.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  single-cycle pulse; connect to the LPF OUT_VALID.
- CYCLE  in  [WIDTH-1:0] x DEPTH  PWM period per transducer.
- DUTY  in  [WIDTH-1:0] x DEPTH  filtered duty (LPF DUTY_S).
- PHASE  in  [WIDTH-1:0] x DEPTH  filtered phase (LPF PHASE_S).
- RISE  out  [WIDTH-1:0] x DEPTH  counter value at which output goes high.
- FALL  out  [WIDTH-1:0] x DEPTH  counter value at which output goes low.
- BUSY  out  1  sweep in progress.
- DONE  out  1  one-cycle pulse; RISE/FALL updated this cycle.

Behaviour:
- Clock and reset: single clock CLK. RST_N is asynchronous, active-low.
- Reset values: state IDLE; RISE, FALL, BUSY and DONE all 0; index counters 0; internal result buffer 0.
- Reset mid-sweep: aborts the sweep; no partial results are published.
- States:
  - IDLE: on START=1, latch all CYCLE/DUTY/PHASE into shadow arrays, clear counters, go to RUN.
  - RUN: feed index 0..DEPTH-1 into the pipeline, one per cycle. Pipeline results are written to the internal buffer. When the last result is written, go to PUBLISH.
  - PUBLISH: copy the buffer to RISE/FALL, pulse DONE, return to IDLE.
- Latency and status: START sampled at cycle 0; DONE=1 at cycle DEPTH+3. BUSY=1 for cycles 1..DEPTH+3 inclusive, 0 otherwise.
- Ignored START: START while BUSY=1, including the DONE cycle, is ignored and not queued.
- Input sampling: inputs are sampled only in the START cycle; later input changes do not affect the current sweep.
- Per-index arithmetic (unsigned WIDTH inputs, signed WIDTH+1 internally). With c=CYCLE, d=DUTY, p=PHASE:
  - Stage 1:
    - dc = min(d, c).
    - pf = p-c if p>=c, else p (single fold only).
  - Stage 2:
    - lo = dc>>1; hi = dc-lo.
    - r = pf-lo; f = pf+hi.
  - Stage 3:
    - RISE = r+c if r<0, else r.
    - FALL = f-c if f>=c, else f.
  - Special cases, evaluated in stage 3 with precedence top to bottom:
    - c==0: RISE=0, FALL=0.
    - dc==0: RISE=0, FALL=0 (output held low).
    - dc==c: RISE=0, FALL=c (never falls inside the period).
- Pipeline stages are registered. Exactly one index enters per RUN cycle; there are no stalls.
- Between DONE pulses, RISE/FALL hold their last published values.

Test Plan:
- Bench configuration: WIDTH=13, DEPTH=4, all CYCLE=4096 unless stated.
- Latency: reset released, START pulse at cycle 0.
  - -> BUSY high cycles 1..7, DONE only at cycle 7.
  - -> RISE/FALL change only at cycle 7.
  - -> second START at cycle 3 ignored (exactly one DONE).
- Basic and odd duty:
  - idx0 d=2048 p=1024 -> RISE=0, FALL=2048.
  - idx1 d=101 p=200 -> RISE=150, FALL=251.
- Wrap-around:
  - idx0 d=100 p=0 -> RISE=4046, FALL=50.
  - idx1 d=10 p=4100 (folds to 4) -> RISE=4095, FALL=9.
- Saturation and zero cases:
  - idx0 d=5000 -> RISE=0, FALL=4096.
  - idx1 d=4096 -> RISE=0, FALL=4096.
  - idx2 d=0 p=777 -> RISE=0, FALL=0.
  - idx3 CYCLE=0 -> RISE=0, FALL=0.
- Input stability and reset:
  - Change DUTY at cycle 2 of a sweep -> results reflect the values sampled at cycle 0.
  - Assert RST_N=0 at cycle 4 -> RISE/FALL/BUSY/DONE are 0 immediately (asynchronously); no DONE follows.
  - Next START after reset completes normally with DONE 7 cycles later.
